// File: rtl/sg_multiplier_pipe.sv
// ---------------------------------------------------------------------------
// sg_multiplier_pipe
//
// Pipelined unsigned significand multiplier for the floating-point MAC
// datapath. Each pipeline stage adds ROWS_PER_STAGE shifted partial-product
// rows into a running sum, so the product is built up over
// LAT = ceil(WIDTH / ROWS_PER_STAGE) stages. A per-stage valid bit tracks
// which stages hold live work. The valid/ready handshake gives one operation
// per clock, and the whole pipe freezes under backpressure.
//
// Parameters
//   WIDTH          significand width in bits, hidden bit included (2..32)
//   ROWS_PER_STAGE partial-product rows summed per stage (1..WIDTH)
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-high reset; clears valid and data
//   flush        synchronous discard of all in-flight operations
//   in_valid     operand pair present
//   in_ready     pipeline can accept this cycle
//   in_sg_A      unsigned significand A (WIDTH bits)
//   in_sg_B      unsigned significand B (WIDTH bits)
//   out_valid    product present
//   out_ready    consumer accepts product
//   out_product  exact unsigned A*B (2*WIDTH bits), zero when out_valid=0
//   out_msb      top product bit, a normalisation hint, zero when out_valid=0
// ---------------------------------------------------------------------------
module sg_multiplier_pipe #(
  parameter int WIDTH          = 11,
  parameter int ROWS_PER_STAGE = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sg_A,
  input  logic [WIDTH-1:0]     in_sg_B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 out_msb
);

  localparam int LAT = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
  localparam int PW  = 2 * WIDTH;

  // Stage registers, index 0 is the first stage and LAT-1 the output stage.
  logic             stage_v   [LAT];
  logic [WIDTH-1:0] stage_a   [LAT];
  logic [WIDTH-1:0] stage_b   [LAT];
  logic [PW-1:0]    stage_sum [LAT];

  // Running sum each stage will capture on the next advance.
  logic [PW-1:0]    next_sum  [LAT];

  logic             advance;

  // Sum of the ROWS_PER_STAGE partial-product rows starting at row 'first'.
  // B is pre-shifted so that rows past the top of B read as zero, which lets
  // a short final stage reuse the same loop without a separate bound check.
  function automatic logic [PW-1:0] row_block(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input int               first
  );
    logic [PW-1:0]    acc;
    logic [PW-1:0]    a_sh;
    logic [WIDTH-1:0] b_sh;
    acc  = '0;
    a_sh = {{WIDTH{1'b0}}, a} << first;
    b_sh = b >> first;
    for (int r = 0; r < ROWS_PER_STAGE; r++) begin
      if (b_sh[0]) begin
        acc = acc + a_sh;
      end
      a_sh = a_sh << 1;
      b_sh = b_sh >> 1;
    end
    return acc;
  endfunction

  // First stage starts the sum from the raw inputs; later stages extend the
  // sum they inherit with their own block of rows.
  assign next_sum[0] = row_block(in_sg_A, in_sg_B, 0);

  for (genvar s = 1; s < LAT; s++) begin : g_stage_sum
    assign next_sum[s] = stage_sum[s-1]
                       + row_block(stage_a[s-1], stage_b[s-1], s * ROWS_PER_STAGE);
  end

  // The pipe moves as one unit: it can shift whenever the output slot is
  // empty or being drained this cycle. Bubbles shift along with real work.
  assign advance  = !stage_v[LAT-1] | out_ready;
  assign in_ready = advance;

  assign out_valid   = stage_v[LAT-1];
  assign out_product = out_valid ? stage_sum[LAT-1] : '0;
  assign out_msb     = out_product[PW-1];

  // Pipeline registers. Flush only kills the valid bits (data contents are
  // irrelevant once invalid) and wins over both advance and stall, so an
  // input presented during a flush cycle is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LAT; s++) begin
        stage_v[s]   <= 1'b0;
        stage_a[s]   <= '0;
        stage_b[s]   <= '0;
        stage_sum[s] <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < LAT; s++) begin
        stage_v[s] <= 1'b0;
      end
    end else if (advance) begin
      stage_v[0]   <= in_valid;
      stage_a[0]   <= in_sg_A;
      stage_b[0]   <= in_sg_B;
      stage_sum[0] <= next_sum[0];
      for (int s = 1; s < LAT; s++) begin
        stage_v[s]   <= stage_v[s-1];
        stage_a[s]   <= stage_a[s-1];
        stage_b[s]   <= stage_b[s-1];
        stage_sum[s] <= next_sum[s];
      end
    end
  end

endmodule

// File: tb/tb_sg_multiplier_pipe.sv
// ---------------------------------------------------------------------------
// tb_sg_multiplier_pipe
//
// Drives two multiplier instances: dut1 (WIDTH=11, one row per stage) and
// dut2 (WIDTH=24, four rows per stage). Stimulus pushes A*B into a
// per-instance queue on every accepted pair; a scoreboard process per
// instance pops and compares whenever a product is presented.
// ---------------------------------------------------------------------------
module tb_sg_multiplier_pipe;

  localparam int W1   = 11;
  localparam int R1   = 1;
  localparam int LAT1 = (W1 + R1 - 1) / R1;
  localparam int W2   = 24;
  localparam int R2   = 4;
  localparam int LAT2 = (W2 + R2 - 1) / R2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset1, flush1, in_valid1, in_ready1, out_valid1, out_ready1, out_msb1;
  logic [W1-1:0]     a1, b1;
  logic [2*W1-1:0]   out_product1;
  logic              reset2, flush2, in_valid2, in_ready2, out_valid2, out_ready2, out_msb2;
  logic [W2-1:0]     a2, b2;
  logic [2*W2-1:0]   out_product2;

  logic [63:0] q1 [$];
  logic [63:0] q2 [$];
  logic [63:0] exp1, exp2, ea, eb;
  int checks = 0;
  int errors = 0;
  int outCount1 = 0;
  int outCount2 = 0;

  sg_multiplier_pipe #(.WIDTH(W1), .ROWS_PER_STAGE(R1)) dut1 (
    .clock(clock), .reset(reset1), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_sg_A(a1), .in_sg_B(b1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_product(out_product1), .out_msb(out_msb1)
  );

  sg_multiplier_pipe #(.WIDTH(W2), .ROWS_PER_STAGE(R2)) dut2 (
    .clock(clock), .reset(reset2), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_sg_A(a2), .in_sg_B(b2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_product(out_product2), .out_msb(out_msb2)
  );

  // Single comparison point: every check funnels through here.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Presents one pair to the chosen instance and holds it until accepted.
  // Entered and left just after a rising edge.
  task automatic applyStimulus(input int dut, input logic [31:0] a, input logic [31:0] b);
    logic ok;
    ok = 1'b0;
    if (dut == 1) begin
      in_valid1 = 1'b1; a1 = a[W1-1:0]; b1 = b[W1-1:0];
    end else begin
      in_valid2 = 1'b1; a2 = a[W2-1:0]; b2 = b[W2-1:0];
    end
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      ok = (dut == 1) ? (in_ready1 && !flush1) : (in_ready2 && !flush2);
      @(posedge clock);
      #2;
      if (ok) break;
    end
    if (!ok) checkOutput("accept_timeout", {63'd0, ok}, 64'd1);
  endtask

  // Waits, bounded, for the instance's expected queue to empty.
  task automatic drain(input int dut);
    int left;
    for (int n = 0; n < 400; n++) begin
      left = (dut == 1) ? q1.size() : q2.size();
      if (left == 0) break;
      @(posedge clock);
      #2;
    end
    left = (dut == 1) ? q1.size() : q2.size();
    checkOutput("drain_pending", 64'(left), 64'd0);
  endtask

  // Sends one pair with out_ready high and counts edges after the accepting
  // edge until the product shows up; it must then last exactly one cycle.
  task automatic measureLatency(input int dut, input logic [31:0] a, input logic [31:0] b);
    int  edges;
    logic v;
    applyStimulus(dut, a, b);
    if (dut == 1) in_valid1 = 1'b0; else in_valid2 = 1'b0;
    edges = 0;
    v = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      v = (dut == 1) ? out_valid1 : out_valid2;
      if (v) break;
      @(posedge clock);
      edges++;
    end
    checkOutput("latency_seen", {63'd0, v}, 64'd1);
    checkOutput("latency_edges", 64'(edges), 64'((dut == 1) ? LAT1 - 1 : LAT2 - 1));
    @(negedge clock);
    v = (dut == 1) ? out_valid1 : out_valid2;
    checkOutput("single_cycle_valid", {63'd0, v}, 64'd0);
    @(posedge clock);
    #2;
  endtask

  // Scoreboards: compare what is presented first, then record this cycle's
  // accept or flush so that a flush never hides the product currently shown.
  always @(negedge clock) begin
    if (out_valid1) begin
      if (q1.size() == 0) begin
        checkOutput("dut1_spurious_valid", {63'd0, out_valid1}, 64'd0);
      end else begin
        exp1 = q1[0];
        checkOutput("dut1_product", 64'(out_product1), exp1);
        checkOutput("dut1_msb", {63'd0, out_msb1}, {63'd0, exp1[2*W1-1]});
        if (out_ready1) begin
          void'(q1.pop_front());
          outCount1++;
        end
      end
    end else begin
      checkOutput("dut1_idle_mask", {41'd0, out_msb1, out_product1}, 64'd0);
    end
    if (!reset1 && flush1) begin
      q1.delete();
    end else if (!reset1 && in_valid1 && in_ready1) begin
      ea = 64'(a1);
      eb = 64'(b1);
      q1.push_back(ea * eb);
    end
  end

  always @(negedge clock) begin
    if (out_valid2) begin
      if (q2.size() == 0) begin
        checkOutput("dut2_spurious_valid", {63'd0, out_valid2}, 64'd0);
      end else begin
        exp2 = q2[0];
        checkOutput("dut2_product", 64'(out_product2), exp2);
        checkOutput("dut2_msb", {63'd0, out_msb2}, {63'd0, exp2[2*W2-1]});
        if (out_ready2) begin
          void'(q2.pop_front());
          outCount2++;
        end
      end
    end else begin
      checkOutput("dut2_idle_mask", {15'd0, out_msb2, out_product2}, 64'd0);
    end
    if (!reset2 && flush2) begin
      q2.delete();
    end else if (!reset2 && in_valid2 && in_ready2) begin
      ea = 64'(a2);
      eb = 64'(b2);
      q2.push_back(ea * eb);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startCount;
    reset1 = 1'b1; flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;
    reset2 = 1'b1; flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;

    // Reset state, then release.
    repeat (3) @(posedge clock);
    #2;
    checkOutput("reset_out_valid", {62'd0, out_valid1, out_valid2}, 64'd0);
    checkOutput("reset_product1", 64'(out_product1), 64'd0);
    checkOutput("reset_product2", 64'(out_product2), 64'd0);
    checkOutput("reset_msb", {62'd0, out_msb1, out_msb2}, 64'd0);
    reset1 = 1'b0;
    reset2 = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", {62'd0, in_ready1, in_ready2}, 64'd3);
    @(posedge clock);
    #2;

    $display("[TB] directed 0x7FF*0x7FF latency");
    measureLatency(1, 32'h7FF, 32'h7FF);
    drain(1);

    $display("[TB] directed 0x400*0x400 then 0x000*0x5A5");
    applyStimulus(1, 32'h400, 32'h400);
    applyStimulus(1, 32'h000, 32'h5A5);
    in_valid1 = 1'b0;
    drain(1);

    $display("[TB] random stream, no backpressure");
    startCount = outCount1;
    fork
      begin
        for (int i = 0; i < 32; i++) applyStimulus(1, $urandom, $urandom);
        in_valid1 = 1'b0;
      end
      begin
        repeat (32) begin
          @(negedge clock);
          checkOutput("stream_in_ready", {63'd0, in_ready1}, 64'd1);
        end
      end
    join
    drain(1);
    checkOutput("stream_count", 64'(outCount1 - startCount), 64'd32);

    $display("[TB] random stream with 5-cycle stall");
    startCount = outCount1;
    fork
      begin
        for (int i = 0; i < 32; i++) applyStimulus(1, $urandom, $urandom);
        in_valid1 = 1'b0;
      end
      begin
        repeat (15) @(posedge clock);
        #2;
        out_ready1 = 1'b0;
        repeat (5) begin
          @(negedge clock);
          checkOutput("stall_in_ready", {63'd0, in_ready1}, 64'd0);
          checkOutput("stall_out_valid", {63'd0, out_valid1}, 64'd1);
        end
        @(posedge clock);
        #2;
        out_ready1 = 1'b1;
      end
    join
    drain(1);
    checkOutput("stall_count", 64'(outCount1 - startCount), 64'd32);

    $display("[TB] flush with pairs in flight");
    startCount = outCount1;
    applyStimulus(1, 32'h111, 32'h222);
    applyStimulus(1, 32'h333, 32'h444);
    applyStimulus(1, 32'h555, 32'h666);
    a1 = 11'h123; b1 = 11'h456; in_valid1 = 1'b1; flush1 = 1'b1;
    @(posedge clock);
    #2;
    flush1 = 1'b0;
    in_valid1 = 1'b0;
    applyStimulus(1, 32'h003, 32'h005);
    in_valid1 = 1'b0;
    drain(1);
    repeat (LAT1 + 4) @(posedge clock);
    #2;
    checkOutput("flush_count", 64'(outCount1 - startCount), 64'd1);

    $display("[TB] flush while stalled");
    out_ready1 = 1'b0;
    applyStimulus(1, 32'h7FF, 32'h001);
    in_valid1 = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (out_valid1) break;
    end
    checkOutput("stalled_valid", {63'd0, out_valid1}, 64'd1);
    @(posedge clock);
    #2;
    flush1 = 1'b1;
    @(posedge clock);
    #2;
    flush1 = 1'b0;
    @(negedge clock);
    checkOutput("flush_stall_out_valid", {63'd0, out_valid1}, 64'd0);
    checkOutput("flush_stall_in_ready", {63'd0, in_ready1}, 64'd1);
    @(posedge clock);
    #2;
    out_ready1 = 1'b1;

    $display("[TB] WIDTH=24 ROWS_PER_STAGE=4");
    measureLatency(2, 32'hFFFFFF, 32'h000001);
    drain(2);
    for (int i = 0; i < 8; i++) applyStimulus(2, $urandom, $urandom);
    in_valid2 = 1'b0;
    drain(2);

    $display("[TB] async reset with ops in flight");
    applyStimulus(2, 32'hABCDEF, 32'h123456);
    applyStimulus(2, 32'h000055, 32'h000066);
    in_valid2 = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    checkOutput("prereset_out_valid", {63'd0, out_valid2}, 64'd1);
    #1;
    reset2 = 1'b1;
    q2.delete();
    #1;
    checkOutput("async_reset_out_valid", {63'd0, out_valid2}, 64'd0);
    checkOutput("async_reset_product", 64'(out_product2), 64'd0);
    @(posedge clock);
    #2;
    reset2 = 1'b0;
    #1;
    checkOutput("release_in_ready", {63'd0, in_ready2}, 64'd1);
    startCount = outCount2;
    repeat (LAT2 + 6) @(posedge clock);
    #2;
    checkOutput("post_reset_silence", 64'(outCount2 - startCount), 64'd0);
    applyStimulus(2, 32'hFFFFFF, 32'hFFFFFF);
    in_valid2 = 1'b0;
    drain(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
